// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit between the EX/MEM and MEM/WB registers.
//   Non-memory instructions pass straight through. Aligned loads and stores
//   run a three-state handshake (IDLE -> WAIT -> DONE) against a data memory
//   that answers with a one-cycle dm_ack pulse. Misaligned accesses raise
//   adel/ades without touching memory.
// Ports:
//   cpu_clk_50M, cpu_rst           clock, synchronous active-high reset
//   mem_i_*                        EX/MEM register contents
//   dm_req/dm_we/dm_addr/dm_be/dm_wdata  registered data-memory request
//   dm_ack/dm_rdata                memory completion pulse and read data
//   mem_o_*                        toward MEM/WB (controls pass combinationally)
//   mem_o_dmdout                   registered load data
//   mem_stall                      pipeline freeze while an access is pending
//   mem_o_exc                      {buserr, ades, adel}
// Optional feature: define MEM_LSU_TIMEOUT_EN to abandon an access after 255
//   WAIT cycles without dm_ack and report buserr.
module mem_lsu (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        mem_i_dre,
  input  logic        mem_i_dwe,
  input  logic [1:0]  mem_i_size,
  input  logic [31:0] mem_i_alures,
  input  logic [31:0] mem_i_wdata,
  input  logic        mem_i_rfwe,
  input  logic [4:0]  mem_i_rfwa,
  input  logic        mem_i_hilowe,
  input  logic        mem_i_loadsign,
  input  logic [63:0] mem_i_mulres,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mem_o_dm2rf,
  output logic        mem_o_rfwe,
  output logic        mem_o_hilowe,
  output logic        mem_o_loadsign,
  output logic [4:0]  mem_o_rfwa,
  output logic [63:0] mem_o_mulres,
  output logic [31:0] mem_o_alures,
  output logic [3:0]  mem_o_bytesel,
  output logic [31:0] mem_o_dmdout,
  output logic        mem_stall,
  output logic [2:0]  mem_o_exc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic        w_stall;
  logic        w_is_mem;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misalign;
  logic        w_misal_hit;
  logic        w_start;
  logic        w_gate;
  logic        w_timeout;
  logic        w_buserr;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        r_is_load;

  // Access decode; size 2'b11 behaves as a word.
  assign w_is_mem   = mem_i_dre | mem_i_dwe;
  assign w_is_half  = (mem_i_size == 2'b01);
  assign w_is_word  = mem_i_size[1];
  assign w_misalign = (w_is_half & mem_i_alures[0]) |
                      (w_is_word & (mem_i_alures[1:0] != 2'b00));
  // Misalignment only matters when a fresh instruction is being looked at.
  assign w_misal_hit = (r_state == S_IDLE) & w_is_mem & w_misalign & ~cpu_rst;
  assign w_start     = (r_state == S_IDLE) & w_is_mem & ~w_misalign;

  // Byte enables and lane-replicated store data.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_i_wdata;
    if (mem_i_size == 2'b00) begin
      w_be    = 4'(4'b0001 << mem_i_alures[1:0]);
      w_wdata = {4{mem_i_wdata[7:0]}};
    end else if (w_is_half) begin
      w_be    = mem_i_alures[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{mem_i_wdata[15:0]}};
    end
  end

  // State register.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next state and combinational stall.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next  = S_WAIT;
          w_stall = 1'b1;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (dm_ack || w_timeout) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (cpu_rst) w_stall = 1'b0;
  end

  // Request registers and load data capture.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_be        <= 4'b0000;
      dm_addr      <= 32'd0;
      dm_wdata     <= 32'd0;
      mem_o_dmdout <= 32'd0;
      r_is_load    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            dm_req    <= 1'b1;
            dm_we     <= mem_i_dwe;
            dm_be     <= w_be;
            dm_addr   <= {mem_i_alures[31:2], 2'b00};
            dm_wdata  <= w_wdata;
            r_is_load <= mem_i_dre;
          end
        end
        S_WAIT: begin
          if (dm_ack) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
            if (r_is_load) mem_o_dmdout <= dm_rdata;
          end else if (w_timeout) begin
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            mem_o_dmdout <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_LSU_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_buserr;

  // The 255th silent WAIT cycle ends the access.
  assign w_timeout = (r_state == S_WAIT) & ~dm_ack & (r_cnt == 8'd254);
  assign w_buserr  = r_buserr;

  // Timeout counter; buserr is held only for the DONE cycle it leads into.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_cnt    <= 8'd0;
      r_buserr <= 1'b0;
    end else begin
      r_buserr <= w_timeout;
      if ((r_state == S_WAIT) && !dm_ack) r_cnt <= r_cnt + 8'd1;
      else                                r_cnt <= 8'd0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_buserr  = 1'b0;
`endif

  // Writeback controls: bubbles while stalled or in reset.
  assign w_gate         = w_stall | cpu_rst;
  assign mem_stall      = w_stall;
  assign mem_o_dm2rf    = mem_i_dre & ~w_gate;
  assign mem_o_rfwe     = mem_i_rfwe & ~w_gate & ~w_misal_hit & ~w_buserr;
  assign mem_o_hilowe   = mem_i_hilowe & ~w_gate;
  assign mem_o_loadsign = mem_i_loadsign;
  assign mem_o_rfwa     = mem_i_rfwa;
  assign mem_o_mulres   = mem_i_mulres;
  assign mem_o_alures   = mem_i_alures;
  assign mem_o_bytesel  = mem_i_dre ? w_be : 4'b0000;
  // Address errors accompany the offending instruction in the same cycle.
  assign mem_o_exc      = {w_buserr & ~cpu_rst,
                           w_misal_hit & mem_i_dwe,
                           w_misal_hit & mem_i_dre};

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu with a scoreboard of expected
// access results and a simple memory responder with programmable ack delay.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        dre, dwe, rfwe, hilowe, loadsign;
  logic [1:0]  size;
  logic [31:0] alures, wdata;
  logic [4:0]  rfwa;
  logic [63:0] mulres;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        o_dm2rf, o_rfwe, o_hilowe, o_loadsign, stall;
  logic [4:0]  o_rfwa;
  logic [63:0] o_mulres;
  logic [31:0] o_alures, o_dmdout;
  logic [3:0]  o_bytesel;
  logic [2:0]  o_exc;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] dmdout;
    logic [3:0]  bytesel;
    logic        rfwe;
    int          stall_n;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_dmdout;

  always #5 clk = ~clk;

  mem_lsu dut (
    .cpu_clk_50M(clk), .cpu_rst(rst),
    .mem_i_dre(dre), .mem_i_dwe(dwe), .mem_i_size(size),
    .mem_i_alures(alures), .mem_i_wdata(wdata), .mem_i_rfwe(rfwe),
    .mem_i_rfwa(rfwa), .mem_i_hilowe(hilowe), .mem_i_loadsign(loadsign),
    .mem_i_mulres(mulres),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_o_dm2rf(o_dm2rf), .mem_o_rfwe(o_rfwe), .mem_o_hilowe(o_hilowe),
    .mem_o_loadsign(o_loadsign), .mem_o_rfwa(o_rfwa), .mem_o_mulres(o_mulres),
    .mem_o_alures(o_alures), .mem_o_bytesel(o_bytesel),
    .mem_o_dmdout(o_dmdout), .mem_stall(stall), .mem_o_exc(o_exc)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'b00) begin
      case (a)
        2'd0:    return 4'b0001;
        2'd1:    return 4'b0010;
        2'd2:    return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (sz == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    dre = 1'b0; dwe = 1'b0; rfwe = 1'b0; hilowe = 1'b0; size = 2'b00;
    alures = 32'd0; wdata = 32'd0; rfwa = 5'd0; dm_ack = 1'b0;
  endtask

  // One aligned access; ack arrives in WAIT cycle number 'delay'.
  task automatic mem_op(input string nm, input logic ld, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int delay);
    exp_t e;
    exp_t g;
    int   stall_n;
    e.addr    = {a[31:2], 2'b00};
    e.be      = m_be(sz, a[1:0]);
    e.wdata   = m_wd(sz, wd);
    e.we      = ~ld;
    e.dmdout  = ld ? rd : last_dmdout;
    e.bytesel = ld ? m_be(sz, a[1:0]) : 4'b0000;
    e.rfwe    = ld;
    e.stall_n = delay + 1;
    sb.push_back(e);
    stall_n = 0;
    step();
    dre = ld; dwe = ~ld; size = sz; alures = a; wdata = wd; rfwe = ld; rfwa = 5'd7;
    @(negedge clk);
    chk({nm, "_idle_stall"}, 96'(stall), 96'(1'b1));
    chk({nm, "_idle_bubble"}, 96'({o_rfwe, o_dm2rf}), 96'(2'b00));
    if (stall) stall_n++;
    for (int w = 1; w <= delay; w++) begin
      step();
      dm_ack   = (w == delay);
      dm_rdata = (w == delay) ? rd : $urandom;
      @(negedge clk);
      chk({nm, "_wait_req"}, {dm_req, dm_we, dm_be, dm_addr, dm_wdata, o_rfwe},
          {1'b1, e.we, e.be, e.addr, e.wdata, 1'b0});
      if (stall) stall_n++;
    end
    step();
    dm_ack = 1'b0;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 96'(0), 96'(1));
    end else begin
      g = sb.pop_front();
      chk({nm, "_done_ctl"}, 96'({stall, dm_req, o_rfwe, o_dm2rf}),
          96'({1'b0, 1'b0, g.rfwe, ld}));
      chk({nm, "_done_data"}, 96'({o_dmdout, o_bytesel}), 96'({g.dmdout, g.bytesel}));
      chk({nm, "_stall_cycles"}, 96'(stall_n), 96'(g.stall_n));
      last_dmdout = g.dmdout;
    end
    step();
    nop();
    @(negedge clk);
    chk({nm, "_after"}, 96'({stall, dm_req}), 96'(2'b00));
  endtask

  initial begin
    rst = 1'b1; loadsign = 1'b0; mulres = 64'h0123_4567_89AB_CDEF; dm_rdata = 32'd0;
    nop();
    last_dmdout = 32'd0;
    step();
    @(negedge clk);
    chk("reset_regs", 96'({dm_req, dm_we, dm_be, o_dmdout, o_exc, stall}), 96'(0));
    step();
    rst = 1'b0;

    // ALU pass-through with a stray ack that must be ignored
    dre = 1'b0; dwe = 1'b0; alures = 32'h1234; rfwe = 1'b1; rfwa = 5'd5;
    hilowe = 1'b1; dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("alu_pass", {o_alures, o_rfwa, o_rfwe, o_hilowe, stall, dm_req, o_dm2rf},
        96'({32'h1234, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    chk("alu_mulres", 96'(o_mulres), 96'(64'h0123_4567_89AB_CDEF));
    step();
    @(negedge clk);
    chk("stray_ack", 96'({dm_req, stall, o_dmdout}), 96'({1'b0, 1'b0, 32'd0}));
    step();
    nop();

    mem_op("lb",  1'b1, 2'b00, 32'h0000_1003, 32'd0, 32'h80AA_BBCC, 1);
    mem_op("sh",  1'b0, 2'b01, 32'h0000_2002, 32'hDEAD_BEEF, 32'd0, 4);
    mem_op("lh",  1'b1, 2'b01, 32'h0000_1000, 32'd0, 32'h1234_5678, 2);
    mem_op("sb",  1'b0, 2'b00, 32'h0000_0011, 32'h0000_00A5, 32'd0, 1);
    mem_op("sw3", 1'b0, 2'b11, 32'h0000_0020, 32'h0102_0304, 32'd0, 3);
    mem_op("lw_slow", 1'b1, 2'b10, 32'h0000_0040, 32'd0, 32'h5555_AAAA, 40);

    // Misaligned load then store
    step();
    dre = 1'b1; size = 2'b10; alures = 32'h0000_3001; rfwe = 1'b1;
    @(negedge clk);
    chk("adel", 96'({o_exc, stall, dm_req, o_rfwe}), 96'({3'b001, 1'b0, 1'b0, 1'b0}));
    step();
    nop();
    dwe = 1'b1; size = 2'b01; alures = 32'h0000_2001;
    @(negedge clk);
    chk("adel_gone", 96'(dm_req), 96'(1'b0));
    chk("ades", 96'({o_exc, stall}), 96'({3'b010, 1'b0}));
    step();
    nop();
    @(negedge clk);
    chk("ades_gone", 96'({o_exc, dm_req}), 96'(0));

    // Reset in WAIT with a coincident ack
    step();
    dre = 1'b1; size = 2'b10; alures = 32'h0000_4000; rfwe = 1'b1;
    step();
    @(negedge clk);
    chk("rst_wait_req", 96'(dm_req), 96'(1'b1));
    step();
    rst = 1'b1; dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rst_gate", 96'({stall, o_rfwe, o_dm2rf}), 96'(0));
    step();
    nop();
    @(negedge clk);
    chk("rst_abandon", 96'({dm_req, o_dmdout, o_exc}), 96'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle", 96'({stall, dm_req}), 96'(0));
    last_dmdout = 32'd0;

`ifdef MEM_LSU_TIMEOUT_EN
    // Refill dmdout so the timeout clear is observable
    mem_op("lw_pre", 1'b1, 2'b10, 32'h0000_0080, 32'd0, 32'h7777_1111, 1);
    begin
      int n;
      n = 0;
      step();
      dre = 1'b1; size = 2'b10; alures = 32'h0000_5000; rfwe = 1'b1;
      for (int k = 0; k < 300; k++) begin
        step();
        @(negedge clk);
        if (!stall) break;
        n++;
      end
      chk("to_wait_cycles", 96'(n), 96'(255));
      chk("to_done", 96'({o_exc, o_dmdout, o_rfwe, dm_req}),
          96'({3'b100, 32'd0, 1'b0, 1'b0}));
      step();
      nop();
      @(negedge clk);
      chk("to_pulse_end", 96'({o_exc, stall}), 96'(0));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
